// File: rtl/capture_fifo.sv
// Two-channel capture FIFO: circular buffer fed by a channel mux.
// It returns occupancy flags to the capture controller and registered read data.
module capture_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Mux,
    input  logic                  Write,
    input  logic                  Read,
    input  logic                  Clear,
    input  logic [DATA_WIDTH-1:0] Ch1_Data,
    input  logic [DATA_WIDTH-1:0] Ch2_Data,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic [ADDR_WIDTH:0]   Count,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0] wp_q, wp_d;
    logic [ADDR_WIDTH-1:0] rp_q, rp_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;
    logic                  dvalid_q, dvalid_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;

    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] wr_data;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign wr_data = Mux ? Ch1_Data : Ch2_Data;

    // Handshake: a write is taken when Write && (!Full || Read); a read is taken
    // when Read && !Empty. Either strobe may be held indefinitely; a request
    // that cannot be taken is dropped and recorded in the sticky flag.
    // Clear overrides both.
    assign wr_acc = Write && (!full || Read) && !Clear;
    assign rd_acc = Read && !empty && !Clear;

    always_comb begin
        wp_d     = wp_q;
        rp_d     = rp_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dvalid_d = 1'b0;
        ovf_d    = ovf_q;
        unf_d    = unf_q;

        if (Clear) begin
            wp_d  = '0;
            rp_d  = '0;
            cnt_d = '0;
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end else begin
            if (wr_acc) begin
                wp_d = wp_q + 1'b1;
            end
            if (rd_acc) begin
                rp_d     = rp_q + 1'b1;
                dout_d   = mem_q[rp_q];
                dvalid_d = 1'b1;
            end
            cnt_d = cnt_q + {{ADDR_WIDTH{1'b0}}, wr_acc} - {{ADDR_WIDTH{1'b0}}, rd_acc};
            if (Write && full && !Read) begin
                ovf_d = 1'b1;
            end
            if (Read && empty) begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wp_q     <= '0;
            rp_q     <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dvalid_q <= 1'b0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wp_q     <= wp_d;
            rp_q     <= rp_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dvalid_q <= dvalid_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is deliberately not reset; occupancy alone decides what is live.
    // On full with a simultaneous read, wp == rp and the read sees the old entry.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wp_q] <= wr_data;
        end
    end

    assign Data_Out   = dout_q;
    assign Data_Valid = dvalid_q;
    assign Full       = full;
    assign Empty      = empty;
    assign Count      = cnt_q;
    assign Overflow   = ovf_q;
    assign Underflow  = unf_q;

endmodule

// File: tb/tb_capture_fifo.sv
// Directed bench for capture_fifo: one task per scenario, inline checks
// against hand-computed values, single summary line at the end.
module tb_capture_fifo;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk;
    logic          reset;
    logic          Mux;
    logic          Write;
    logic          Read;
    logic          Clear;
    logic [DW-1:0] Ch1_Data;
    logic [DW-1:0] Ch2_Data;
    logic [DW-1:0] Data_Out;
    logic          Data_Valid;
    logic          Full;
    logic          Empty;
    logic [AW:0]   Count;
    logic          Overflow;
    logic          Underflow;

    int n_cmp = 0;
    int n_err = 0;

    capture_fifo #(.DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .Mux       (Mux),
        .Write     (Write),
        .Read      (Read),
        .Clear     (Clear),
        .Ch1_Data  (Ch1_Data),
        .Ch2_Data  (Ch2_Data),
        .Data_Out  (Data_Out),
        .Data_Valid(Data_Valid),
        .Full      (Full),
        .Empty     (Empty),
        .Count     (Count),
        .Overflow  (Overflow),
        .Underflow (Underflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        Write = 1'b0;
        Read  = 1'b0;
        Clear = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] v);
        Mux = 1'b1; Ch1_Data = v; Ch2_Data = ~v; Write = 1'b1; Read = 1'b0;
        tick();
        Write = 1'b0;
    endtask

    task automatic do_clear();
        idle(); Clear = 1'b1;
        tick();
        Clear = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (Count !== 5'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", Count); end
        n_cmp++; if (Empty !== 1'b1) begin n_err++; $display("FAIL reset_empty got %b exp 1", Empty); end
        n_cmp++; if (Full !== 1'b0) begin n_err++; $display("FAIL reset_full got %b exp 0", Full); end
        n_cmp++; if (Data_Out !== 8'h00) begin n_err++; $display("FAIL reset_dout got %h exp 00", Data_Out); end
        n_cmp++; if (Data_Valid !== 1'b0) begin n_err++; $display("FAIL reset_dvalid got %b exp 0", Data_Valid); end
        n_cmp++; if ({Overflow, Underflow} !== 2'b00) begin n_err++; $display("FAIL reset_sticky got %b exp 00", {Overflow, Underflow}); end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h10 + i));
            n_cmp++; if (Count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, Count, i + 1); end
        end
        n_cmp++; if (Full !== 1'b1) begin n_err++; $display("FAIL fill_full got %b exp 1", Full); end
        Read = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tick();
            n_cmp++; if (Data_Out !== 8'(8'h10 + i) || Data_Valid !== 1'b1)
                begin n_err++; $display("FAIL drain_data[%0d] got %h/%b exp %h/1", i, Data_Out, Data_Valid, 8'(8'h10 + i)); end
            n_cmp++; if (Count !== 5'(15 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, Count, 15 - i); end
        end
        Read = 1'b0;
        n_cmp++; if (Empty !== 1'b1 || Full !== 1'b0) begin n_err++; $display("FAIL drain_empty got E=%b F=%b exp E=1 F=0", Empty, Full); end
        tick();
        n_cmp++; if (Data_Valid !== 1'b0 || Data_Out !== 8'h1F) begin n_err++; $display("FAIL drain_idle got %h/%b exp 1f/0", Data_Out, Data_Valid); end
    endtask

    task automatic test_channel_select();
        Write = 1'b1; Mux = 1'b1; Ch1_Data = 8'hA1; Ch2_Data = 8'hB1;
        tick();
        Mux = 1'b0; Ch1_Data = 8'hA2; Ch2_Data = 8'hB2;
        tick();
        Write = 1'b0; Read = 1'b1;
        tick();
        n_cmp++; if (Data_Out !== 8'hA1 || Data_Valid !== 1'b1) begin n_err++; $display("FAIL chsel_first got %h/%b exp a1/1", Data_Out, Data_Valid); end
        tick();
        n_cmp++; if (Data_Out !== 8'hB2 || Data_Valid !== 1'b1) begin n_err++; $display("FAIL chsel_second got %h/%b exp b2/1", Data_Out, Data_Valid); end
        Read = 1'b0;
        tick();
    endtask

    task automatic test_full_rw_overflow();
        for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
        Mux = 1'b1; Ch1_Data = 8'h55; Write = 1'b1; Read = 1'b1;
        tick();
        n_cmp++; if (Data_Out !== 8'h20 || Data_Valid !== 1'b1) begin n_err++; $display("FAIL fullrw_data got %h/%b exp 20/1", Data_Out, Data_Valid); end
        n_cmp++; if (Count !== 5'd16 || Full !== 1'b1) begin n_err++; $display("FAIL fullrw_count got %0d/%b exp 16/1", Count, Full); end
        Read = 1'b0; Ch1_Data = 8'h66;
        tick();
        n_cmp++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag got %b exp 1", Overflow); end
        n_cmp++; if (Count !== 5'd16 || Data_Valid !== 1'b0) begin n_err++; $display("FAIL ovf_count got %0d/%b exp 16/0", Count, Data_Valid); end
        Write = 1'b0; Read = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            n_cmp++; if (Data_Out !== 8'(8'h21 + i)) begin n_err++; $display("FAIL fullrw_drain[%0d] got %h exp %h", i, Data_Out, 8'(8'h21 + i)); end
        end
        tick();
        n_cmp++; if (Data_Out !== 8'h55 || Empty !== 1'b1) begin n_err++; $display("FAIL fullrw_last got %h/E=%b exp 55/1", Data_Out, Empty); end
        n_cmp++; if (Overflow !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b exp 1", Overflow); end
        Read = 1'b0;
        do_clear();
        n_cmp++; if (Overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %b exp 0", Overflow); end
    endtask

    task automatic test_empty_cases();
        Read = 1'b1;
        tick();
        n_cmp++; if (Data_Valid !== 1'b0 || Underflow !== 1'b1 || Data_Out !== 8'h55)
            begin n_err++; $display("FAIL empty_read got v=%b u=%b d=%h exp v=0 u=1 d=55", Data_Valid, Underflow, Data_Out); end
        Write = 1'b1; Mux = 1'b1; Ch1_Data = 8'h77;
        tick();
        n_cmp++; if (Count !== 5'd1 || Data_Valid !== 1'b0 || Data_Out !== 8'h55)
            begin n_err++; $display("FAIL empty_rw got c=%0d v=%b d=%h exp c=1 v=0 d=55", Count, Data_Valid, Data_Out); end
        Write = 1'b0;
        tick();
        n_cmp++; if (Data_Out !== 8'h77 || Data_Valid !== 1'b1 || Count !== 5'd0)
            begin n_err++; $display("FAIL empty_next got d=%h v=%b c=%0d exp 77/1/0", Data_Out, Data_Valid, Count); end
        Read = 1'b0;
        do_clear();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 3; i++) push(8'(8'h80 + i));
        Mux = 1'b1; Write = 1'b1; Read = 1'b1;
        for (int i = 0; i < 40; i++) begin
            Ch1_Data = 8'(8'h83 + i);
            tick();
            n_cmp++; if (Data_Out !== 8'(8'h80 + i) || Data_Valid !== 1'b1 || Count !== 5'd3)
                begin n_err++; $display("FAIL wrap[%0d] got d=%h v=%b c=%0d exp %h/1/3", i, Data_Out, Data_Valid, Count, 8'(8'h80 + i)); end
        end
        Write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (Data_Out !== 8'(8'hA8 + i)) begin n_err++; $display("FAIL wrap_tail[%0d] got %h exp %h", i, Data_Out, 8'(8'hA8 + i)); end
        end
        Read = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
        Write = 1'b1;
        tick();
        Write = 1'b0; Read = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        Read = 1'b0;
        n_cmp++; if (Count !== 5'd9 || Overflow !== 1'b1 || Data_Valid !== 1'b1)
            begin n_err++; $display("FAIL rstmid_pre got c=%0d o=%b v=%b exp 9/1/1", Count, Overflow, Data_Valid); end
        #2 reset = 1'b0;
        #1;
        n_cmp++; if (Count !== 5'd0 || Empty !== 1'b1 || Full !== 1'b0)
            begin n_err++; $display("FAIL rstmid_count got c=%0d e=%b f=%b exp 0/1/0", Count, Empty, Full); end
        n_cmp++; if (Data_Out !== 8'h00 || Data_Valid !== 1'b0 || Overflow !== 1'b0 || Underflow !== 1'b0)
            begin n_err++; $display("FAIL rstmid_out got d=%h v=%b o=%b u=%b exp 00/0/0/0", Data_Out, Data_Valid, Overflow, Underflow); end
        @(negedge clk);
        reset = 1'b1;
        push(8'h3C);
        Read = 1'b1;
        tick();
        Read = 1'b0;
        n_cmp++; if (Data_Out !== 8'h3C || Empty !== 1'b1) begin n_err++; $display("FAIL rstmid_after got %h/E=%b exp 3c/1", Data_Out, Empty); end
    endtask

    task automatic test_clear();
        Read = 1'b1;
        tick();
        Read = 1'b0;
        push(8'h91);
        push(8'h92);
        n_cmp++; if (Underflow !== 1'b1 || Count !== 5'd2) begin n_err++; $display("FAIL clr_pre got u=%b c=%0d exp 1/2", Underflow, Count); end
        Clear = 1'b1; Write = 1'b1; Mux = 1'b1; Ch1_Data = 8'h99;
        tick();
        idle();
        n_cmp++; if (Count !== 5'd0 || Empty !== 1'b1 || Overflow !== 1'b0 || Underflow !== 1'b0 || Data_Valid !== 1'b0)
            begin n_err++; $display("FAIL clr_state got c=%0d e=%b o=%b u=%b v=%b exp 0/1/0/0/0", Count, Empty, Overflow, Underflow, Data_Valid); end
        Read = 1'b1;
        tick();
        Read = 1'b0;
        n_cmp++; if (Data_Valid !== 1'b0 || Underflow !== 1'b1 || Data_Out !== 8'h3C)
            begin n_err++; $display("FAIL clr_discard got v=%b u=%b d=%h exp 0/1/3c", Data_Valid, Underflow, Data_Out); end
    endtask

    initial begin
        reset = 1'b0; Mux = 1'b0; Ch1_Data = '0; Ch2_Data = '0;
        idle();
        #2;
        test_reset();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        test_fill_drain();
        test_channel_select();
        test_full_rw_overflow();
        test_empty_cases();
        test_wrap();
        test_reset_mid();
        test_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/capture_fifo.md
# capture_fifo

Two-channel capture FIFO that sits directly downstream of the capture-control state machine. It takes that controller's `Mux`, `Write` and `Read` strobes, selects one of two input channels, and stores samples in a circular buffer. It returns the `Full` and `Empty` flags the controller uses to move from loading to finish and from reading back to idle. Read-back data comes out registered, with a one-cycle valid strobe, for the downstream consumer.

## Interface
- `DATA_WIDTH`, 8: sample width in bits for both channels and the output.
- `DEPTH`, 16: number of entries; must be a power of two, minimum 2.
- `ADDR_WIDTH`, 4: log2(`DEPTH`); pointers are this wide and the count is `ADDR_WIDTH+1` bits wide.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Mux` input 1: channel select; 1 selects `Ch1_Data`, 0 selects `Ch2_Data`.
- `Write` input 1: write request for the selected channel's sample.
- `Read` input 1: read request.
- `Clear` input 1: synchronous flush, active high.
- `Ch1_Data` input `DATA_WIDTH`: channel 1 sample.
- `Ch2_Data` input `DATA_WIDTH`: channel 2 sample.
- `Data_Out` output `DATA_WIDTH`: registered read data.
- `Data_Valid` output 1: one-cycle pulse marking that `Data_Out` was loaded by an accepted read.
- `Full` output 1: high when count == `DEPTH`.
- `Empty` output 1: high when count == 0.
- `Count` output `ADDR_WIDTH+1`: current occupancy, 0..`DEPTH`.
- `Overflow` output 1: sticky; set by a rejected write.
- `Underflow` output 1: sticky; set by a rejected read.

## Operation
- **Storage:** `DEPTH` x `DATA_WIDTH` array, write pointer `wp`, read pointer `rp`, occupancy `cnt`. The array is not reset.
- **Write acceptance:** a write is accepted when `Write` && (!`Full` || `Read`).
  - On acceptance: mem[`wp`] <= (`Mux` ? `Ch1_Data` : `Ch2_Data`), and `wp` <= `wp`+1 modulo `DEPTH`.
  - The channel is sampled on the same edge as `Write`.
- **Read acceptance:** a read is accepted when `Read` && !`Empty`.
  - On acceptance: `Data_Out` <= mem[`rp`], `rp` <= `rp`+1 modulo `DEPTH`, and `Data_Valid` <= 1.
  - Otherwise `Data_Valid` <= 0 and `Data_Out` holds its value.
- **No fall-through:** when `Empty`, a simultaneous `Read` and `Write` performs the write only. The read is rejected and `Underflow` is set.
- **Full with simultaneous read:** both the read and the write are accepted. `cnt` stays at `DEPTH`, and the read returns the oldest entry, not the incoming sample.
- **Count update:** `cnt` += accepted write − accepted read.
- **Overflow:** set when `Write` && `Full` && !`Read`. The sample is dropped and no state changes.
- **Underflow:** set on any rejected read.
- **Sticky flags:** `Overflow` and `Underflow` clear only on `reset` or `Clear`.
- **Clear:** has priority over `Read` and `Write` in the same cycle. It sets `wp`, `rp` and `cnt` to 0, `Data_Valid` to 0 and both sticky flags to 0. `Data_Out` holds its value.
- **Pointer wrap:** pointers wrap from `DEPTH`−1 to 0 with no special handling; fullness is tracked by `cnt`, never by pointer comparison.

## Timing
- **Reset (asynchronous, active low):**
  - `wp` = `rp` = 0 and `Count` = 0.
  - `Empty` = 1 and `Full` = 0.
  - `Data_Out` = 0 and `Data_Valid` = 0.
  - `Overflow` = 0 and `Underflow` = 0.
- **Reset mid-operation:** all stored entries are discarded, and the outputs above take effect immediately, without waiting for a clock edge.
- **Flags and count:** `Full`, `Empty` and `Count` are decoded from registered `cnt`. They change in the cycle after the edge that accepted the access.
  - Example: the 16th write edge is edge N, and `Full` reads 1 from edge N onward, so the controller leaves loading on edge N+1.
- **Read latency:** `Data_Out` and `Data_Valid` update on the edge that accepts the read. Data is valid in the cycle after `Read` was sampled.
- **Back-to-back:** one write and one read per cycle, sustained indefinitely at any occupancy from 1 to `DEPTH`.
- **Handshake with the controller:**
  - Writes are held by the controller while it is loading; the FIFO tolerates `Write` persisting while `Full` (Overflow case).
  - Reads are held by the controller while reading back; the FIFO tolerates `Read` persisting while `Empty` (Underflow case).
  - The controller treats the sticky flags as diagnostics only.

## Test plan
- **Fill and drain:** with `Mux`=1, write 16 samples on `Ch1_Data` = 0x10..0x1F.
  - `Full`=1 and `Count`=16 after the 16th edge.
  - Then read 16 times: `Data_Out` = 0x10..0x1F in order, with `Data_Valid` high for each, and `Empty`=1 after the last read.
- **Channel select:** write 0xA1 with `Mux`=1 (`Ch2_Data`=0xB1), then 0xB2 with `Mux`=0 (`Ch1_Data`=0xA2).
  - Reads return 0xA1 then 0xB2.
- **Full, simultaneous read/write, and overflow:** at `Full`, assert `Write`+`Read` with new sample 0x55.
  - Returns the oldest entry, `Count` stays 16, and 0x55 is read last.
  - Next, `Write` alone while `Full`: `Overflow`=1 and `Count` stays 16.
- **Empty cases:** `Read` with `Empty`=1 gives `Data_Valid`=0, `Underflow`=1 and `Data_Out` unchanged.
  - `Read`+`Write` of 0x77 when empty gives `Count`=1 and `Data_Valid`=0; the next read returns 0x77.
- **Wrap-around:** run 40 write/read pairs at occupancy 3.
  - Data comes out in order with no loss across the pointer wraps, and `Count` holds 3.
- **Reset and clear:** assert `reset` low mid-cycle with `Count`=9 and `Overflow`=1.
  - Outputs go to reset values immediately.
  - Separately, `Clear` with `Write` asserted gives `Count`=0, flags 0 and the write discarded.
